// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
// Round-robin arbiter sharing one memory/MMIO port between fetch, load/store
// and the UART boot loader, with an optional access timeout.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK100MHZ,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [95:0] addr,
  input  logic [95:0] wdata,
  input  logic [11:0] wstrb,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int c_NREQ  = 3;
  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state,     w_state_n;
  logic [1:0]         r_last,      w_last_n;
  logic [1:0]         r_grant,     w_grant_n;
  logic [c_CNT_W-1:0] r_cnt,       w_cnt_n;
  logic [2:0]         r_done,      w_done_n;
  logic [2:0]         r_err,       w_err_n;
  logic [31:0]        r_rdata,     w_rdata_n;
  logic               r_mem_req,   w_mem_req_n;
  logic               r_mem_we,    w_mem_we_n;
  logic [31:0]        r_mem_addr,  w_mem_addr_n;
  logic [31:0]        r_mem_wdata, w_mem_wdata_n;
  logic [3:0]         r_mem_wstrb, w_mem_wstrb_n;

  logic [31:0] w_addr_lane  [c_NREQ];
  logic [31:0] w_wdata_lane [c_NREQ];
  logic [3:0]  w_wstrb_lane [c_NREQ];

  generate
    for (genvar gi = 0; gi < c_NREQ; gi++) begin : g_lane
      assign w_addr_lane[gi]  = addr[32*gi +: 32];
      assign w_wdata_lane[gi] = wdata[32*gi +: 32];
      assign w_wstrb_lane[gi] = wstrb[4*gi +: 4];
    end
  endgenerate

  // Search begins one past the previous winner; last=2 after reset yields 0,1,2.
  logic [1:0] w_first, w_second, w_third, w_win;
  always_comb begin
    w_first  = (r_last == 2'd2)   ? 2'd0 : r_last + 2'd1;
    w_second = (w_first == 2'd2)  ? 2'd0 : w_first + 2'd1;
    w_third  = (w_second == 2'd2) ? 2'd0 : w_second + 2'd1;
    if (req[w_first])
      w_win = w_first;
    else if (req[w_second])
      w_win = w_second;
    else
      w_win = w_third;
  end

  logic       w_timeout;
  logic [2:0] w_grant_oh;
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);
  assign w_grant_oh = 3'b001 << r_grant;

  always_comb begin
    w_state_n     = r_state;
    w_last_n      = r_last;
    w_grant_n     = r_grant;
    w_cnt_n       = r_cnt;
    w_done_n      = 3'b000;
    w_err_n       = 3'b000;
    w_rdata_n     = r_rdata;
    w_mem_req_n   = r_mem_req;
    w_mem_we_n    = r_mem_we;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_mem_wstrb_n = r_mem_wstrb;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_mem_req_n   = 1'b1;
          w_mem_we_n    = we[w_win];
          w_mem_addr_n  = w_addr_lane[w_win];
          w_mem_wdata_n = w_wdata_lane[w_win];
          w_mem_wstrb_n = w_wstrb_lane[w_win];
          w_grant_n     = w_win;
          w_last_n      = w_win;
          w_cnt_n       = '0;
          w_state_n     = S_BUSY;
        end
      end
      S_BUSY: begin
        w_cnt_n = r_cnt + 1'b1;
        // An acknowledge in the timeout cycle still counts as a clean completion.
        if (mem_ready) begin
          w_rdata_n   = mem_rdata;
          w_mem_req_n = 1'b0;
          w_done_n    = w_grant_oh;
          w_state_n   = S_DONE;
        end else if (w_timeout) begin
          w_rdata_n   = '0;
          w_mem_req_n = 1'b0;
          w_done_n    = w_grant_oh;
          w_err_n     = w_grant_oh;
          w_state_n   = S_DONE;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n   = S_IDLE;
        w_mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd2;
      r_grant     <= 2'd0;
      r_cnt       <= '0;
      r_done      <= 3'b000;
      r_err       <= 3'b000;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state     <= w_state_n;
      r_last      <= w_last_n;
      r_grant     <= w_grant_n;
      r_cnt       <= w_cnt_n;
      r_done      <= w_done_n;
      r_err       <= w_err_n;
      r_rdata     <= w_rdata_n;
      r_mem_req   <= w_mem_req_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_wstrb <= w_mem_wstrb_n;
    end
  end

  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign busy      = (r_state == S_BUSY) || (r_state == S_DONE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter
// Randomised self-checking bench for mem_port_arbiter against a round-robin model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        CLK100MHZ = 1'b0;
  logic        resetn    = 1'b0;
  logic [2:0]  req       = '0;
  logic [2:0]  we        = '0;
  logic [95:0] addr      = '0;
  logic [95:0] wdata     = '0;
  logic [11:0] wstrb     = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  done, err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        busy, mem_req, mem_we;
  logic [3:0]  mem_wstrb;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_last = 2;

  // Observations of the most recent access.
  bit          a_got, a_uns, a_bb;
  int          a_cyc, a_rc;
  logic [2:0]  a_done, a_err;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic        a_we;
  logic [3:0]  a_wstrb;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .CLK100MHZ(CLK100MHZ), .resetn(resetn), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .done(done), .err(err), .rdata(rdata),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1);
  end

  // Round-robin reference: first requester at (last+k) mod 3, k=1..3.
  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  // Memory responder: acknowledges after 'waits' cycles of mem_req; records outputs.
  task automatic access(input int waits, input logic [31:0] rd, input bit scramble);
    a_got = 0; a_uns = 0; a_bb = 0; a_cyc = 0; a_rc = 0;
    a_done = '0; a_err = '0; a_rdata = '0; a_we = 0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    while (!a_got && a_cyc < 60) begin
      @(posedge CLK100MHZ); #1;
      a_cyc++;
      if (busy !== 1'b1) a_bb = 1;
      if (done !== 3'b000) begin
        a_got = 1; a_done = done; a_err = err; a_rdata = rdata;
        mem_ready = 1'b0;
      end else if (mem_req === 1'b1) begin
        if (a_rc == 0) begin
          a_we = mem_we; a_addr = mem_addr; a_wdata = mem_wdata; a_wstrb = mem_wstrb;
        end else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {a_we, a_addr, a_wdata, a_wstrb}) begin
          a_uns = 1;
        end
        a_rc++;
        mem_ready = (a_rc > waits);
        mem_rdata = mem_ready ? rd : $urandom;
        if (scramble) begin
          req = 3'($urandom); we = 3'($urandom);
          addr = {$urandom, $urandom, $urandom}; wdata = {$urandom, $urandom, $urandom};
          wstrb = 12'($urandom);
        end
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = '0; mem_ready = 1'b0;
    repeat (2) @(posedge CLK100MHZ);
    #1;
    n_cmp++;
    if ({done, err, rdata, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b err=%b rdata=%h busy=%b mem_req=%b mem_we=%b addr=%h wdata=%h wstrb=%b, required all zero",
               done, err, rdata, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    resetn = 1'b1;
    model_last = 2;
  endtask

  task automatic test_single_read();
    int exp;
    req = 3'b001; we = 3'b000; addr = {$urandom, $urandom, 32'h0000_0100};
    exp = rr_pick(req, model_last);
    access(2, 32'hCAFE_F00D, 0);
    model_last = exp;
    req = 3'b000;
    n_cmp++;
    if (!a_got) begin n_fail++; $display("FAIL read_done_seen: got none required done pulse"); end
    n_cmp++;
    if (a_rc != 3 || a_addr !== 32'h100 || a_we !== 1'b0 || a_uns) begin
      n_fail++;
      $display("FAIL read_port: got cycles=%0d addr=%h we=%b unstable=%0d required 3/00000100/0/0", a_rc, a_addr, a_we, a_uns);
    end
    n_cmp++;
    if (a_done !== 3'b001 || a_err !== 3'b000 || a_rdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL read_completion: got done=%b err=%b rdata=%h required 001/000/cafef00d", a_done, a_err, a_rdata);
    end
    n_cmp++;
    if (a_bb) begin n_fail++; $display("FAIL read_busy: got busy low during access required high"); end
    @(posedge CLK100MHZ); #1;
    n_cmp++;
    if ({done, err, busy, mem_req} !== '0) begin
      n_fail++;
      $display("FAIL read_after_done: got done=%b err=%b busy=%b mem_req=%b required all zero", done, err, busy, mem_req);
    end
  endtask

  task automatic test_write();
    int exp;
    req = 3'b010; we = 3'b010;
    addr  = {$urandom, 32'h2000_0004, $urandom};
    wdata = {$urandom, 32'h0000_0055, $urandom};
    wstrb = {4'hF, 4'b0001, 4'hE};
    exp = rr_pick(req, model_last);
    access(1, $urandom, 0);
    model_last = exp;
    req = 3'b000;
    n_cmp++;
    if (a_we !== 1'b1 || a_addr !== 32'h2000_0004 || a_wdata !== 32'h55 || a_wstrb !== 4'b0001 || a_uns || a_rc != 2) begin
      n_fail++;
      $display("FAIL write_port: got we=%b addr=%h wdata=%h wstrb=%b unstable=%0d cycles=%0d required 1/20000004/00000055/0001/0/2",
               a_we, a_addr, a_wdata, a_wstrb, a_uns, a_rc);
    end
    n_cmp++;
    if (!a_got || a_done !== 3'b010 || a_err !== 3'b000) begin
      n_fail++;
      $display("FAIL write_done: got done=%b err=%b required 010/000", a_done, a_err);
    end
    @(posedge CLK100MHZ); #1;
  endtask

  task automatic test_fairness();
    int exp;
    test_reset();
    req = 3'b111; we = 3'($urandom);
    addr = {$urandom, $urandom, $urandom}; wdata = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      exp = rr_pick(req, model_last);
      access(0, $urandom, 0);
      model_last = exp;
      n_cmp++;
      if (!a_got || a_done !== (3'b001 << (i % 3)) || a_done !== (3'b001 << exp) || a_cyc != 2) begin
        n_fail++;
        $display("FAIL fair_grant%0d: got done=%b cycles=%0d required done=%b cycles=2", i, a_done, a_cyc, 3'b001 << exp);
      end
      req = 3'b111 & ~a_done;
      @(posedge CLK100MHZ); #1;
      req = (i == 5) ? 3'b000 : 3'b111;
    end
  endtask

  task automatic test_timeout();
    int exp;
    req = 3'b100; we = 3'b100; addr = {$urandom, $urandom, $urandom};
    exp = rr_pick(req, model_last);
    access(1000, $urandom, 0);
    model_last = exp;
    req = 3'b000;
    n_cmp++;
    if (a_rc != TO) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d required %0d", a_rc, TO); end
    n_cmp++;
    if (!a_got || a_done !== 3'b100 || a_err !== 3'b100 || a_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_completion: got done=%b err=%b rdata=%h required 100/100/00000000", a_done, a_err, a_rdata);
    end
    @(posedge CLK100MHZ); #1;
    req = 3'b001;
    exp = rr_pick(req, model_last);
    access(0, 32'h1234_5678, 0);
    model_last = exp;
    req = 3'b000;
    n_cmp++;
    if (!a_got || a_done !== 3'b001 || a_err !== 3'b000 || a_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL timeout_recovery: got done=%b err=%b rdata=%h required 001/000/12345678", a_done, a_err, a_rdata);
    end
    @(posedge CLK100MHZ); #1;
  endtask

  task automatic test_tie();
    int exp;
    req = 3'b010;
    exp = rr_pick(req, model_last);
    access(TO - 1, 32'hA5A5_0F0F, 0);
    model_last = exp;
    req = 3'b000;
    n_cmp++;
    if (!a_got || a_done !== 3'b010 || a_err !== 3'b000 || a_rdata !== 32'hA5A5_0F0F || a_rc != TO) begin
      n_fail++;
      $display("FAIL tie: got done=%b err=%b rdata=%h cycles=%0d required 010/000/a5a50f0f/%0d", a_done, a_err, a_rdata, a_rc, TO);
    end
    @(posedge CLK100MHZ); #1;
  endtask

  task automatic test_reset_mid_busy();
    int exp;
    req = 3'b001; we = 3'b000; mem_ready = 1'b0;
    @(posedge CLK100MHZ); #1;
    n_cmp++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_started: got mem_req=%b required 1", mem_req); end
    @(posedge CLK100MHZ); #1;
    resetn = 1'b0;
    @(posedge CLK100MHZ); #1;
    n_cmp++;
    if ({done, err, rdata, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got done=%b err=%b busy=%b mem_req=%b addr=%h required all zero", done, err, busy, mem_req, mem_addr);
    end
    resetn = 1'b1; req = 3'b011;
    model_last = 2;
    exp = rr_pick(req, model_last);
    access(0, $urandom, 0);
    model_last = exp;
    req = 3'b000;
    n_cmp++;
    if (!a_got || a_done !== 3'b001) begin
      n_fail++;
      $display("FAIL midrst_first_grant: got done=%b required 001", a_done);
    end
    @(posedge CLK100MHZ); #1;
  endtask

  task automatic test_random();
    int exp, waits;
    logic [31:0] rd, e_addr, e_wdata;
    logic [3:0] e_wstrb;
    logic e_we, e_err;
    for (int i = 0; i < 40; i++) begin
      req = 3'($urandom_range(1, 7)); we = 3'($urandom);
      addr = {$urandom, $urandom, $urandom}; wdata = {$urandom, $urandom, $urandom};
      wstrb = 12'($urandom);
      waits = $urandom_range(0, 5);
      rd = $urandom;
      exp = rr_pick(req, model_last);
      e_addr = addr[32*exp +: 32]; e_wdata = wdata[32*exp +: 32];
      e_wstrb = wstrb[4*exp +: 4]; e_we = we[exp];
      e_err = (waits >= TO);
      access(waits, rd, ($urandom_range(0, 1) == 1));
      model_last = exp;
      req = 3'b000;
      n_cmp++;
      if (!a_got || a_done !== (3'b001 << exp) || a_err !== (e_err ? (3'b001 << exp) : 3'b000)) begin
        n_fail++;
        $display("FAIL rnd_completion it=%0d: got done=%b err=%b required done=%b err=%b",
                 i, a_done, a_err, 3'b001 << exp, e_err ? (3'b001 << exp) : 3'b000);
      end
      n_cmp++;
      if (a_rdata !== (e_err ? 32'h0 : rd)) begin
        n_fail++;
        $display("FAIL rnd_rdata it=%0d: got %h required %h", i, a_rdata, e_err ? 32'h0 : rd);
      end
      n_cmp++;
      if ({a_we, a_addr, a_wdata, a_wstrb} !== {e_we, e_addr, e_wdata, e_wstrb} || a_uns) begin
        n_fail++;
        $display("FAIL rnd_port it=%0d: got we=%b addr=%h wdata=%h wstrb=%b unstable=%0d required %b/%h/%h/%b/0",
                 i, a_we, a_addr, a_wdata, a_wstrb, a_uns, e_we, e_addr, e_wdata, e_wstrb);
      end
      n_cmp++;
      if (a_rc != (e_err ? TO : waits + 1)) begin
        n_fail++;
        $display("FAIL rnd_req_cycles it=%0d: got %0d required %0d", i, a_rc, e_err ? TO : waits + 1);
      end
      @(posedge CLK100MHZ); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fairness();
    test_timeout();
    test_tie();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
